// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI receiver.
// Contents: opcode constants, decoder state enum, argument-count lookup, clamp helper.
package oled_pkg;

  localparam logic [7:0] CMD_COL_ADDR = 8'h15;
  localparam logic [7:0] CMD_ROW_ADDR = 8'h75;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;

  typedef enum logic [0:0] {IDLE, ARG} dec_state_e;

  // Number of argument bytes that follow a command opcode.
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    if (op == CMD_COL_ADDR || op == CMD_ROW_ADDR) begin
      return 2'd2;
    end else if ((op >= 8'hA4 && op <= 8'hA7) || op == CMD_DISP_OFF || op == CMD_DISP_ON ||
                 op == 8'hE3) begin
      return 2'd0;
    end else begin
      return 2'd1;
    end
  endfunction

  function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// Serial front end of the OLED SPI receiver.
// Synchronizes oled_clk/din/cs/dc/res_n into the clk domain, detects oled_clk rising edges,
// assembles MSB-first bytes and presents each one with a single-cycle byte_valid.
// Ports:
//   clk, rst            system clock, async active-high reset
//   oled_clk, din, cs, dc, res_n   raw serial inputs
//   res_act             synchronized display reset (active high)
//   byte_valid          one-cycle pulse per completed byte
//   byte_data, byte_dc  received byte and the DC level captured with its last bit
module oled_spi_shifter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oled_clk,
  input  logic       din,
  input  logic       cs,
  input  logic       dc,
  input  logic       res_n,
  output logic       res_act,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [SYNC_STAGES-1:0] clk_sync_q, din_sync_q, cs_sync_q, dc_sync_q, res_sync_q;
  logic       clk_prev_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       dc_q, dc_d;

  logic clk_s, din_s, cs_s, dc_s, rise;

  assign clk_s   = clk_sync_q[SYNC_STAGES-1];
  assign din_s   = din_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign dc_s    = dc_sync_q[SYNC_STAGES-1];
  assign res_act = ~res_sync_q[SYNC_STAGES-1];
  assign rise    = clk_s & ~clk_prev_q;

  // cs idles deasserted; res_n sync resets asserted so the decoder stays held until it clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '0;
      din_sync_q <= '0;
      cs_sync_q  <= '1;
      dc_sync_q  <= '0;
      res_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], oled_clk};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      dc_sync_q  <= {dc_sync_q[SYNC_STAGES-2:0], dc};
      res_sync_q <= {res_sync_q[SYNC_STAGES-2:0], res_n};
      clk_prev_q <= clk_s;
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    data_d  = data_q;
    dc_d    = dc_q;
    if (res_act || cs_s) begin
      // Partial bits never survive a deselect or display reset.
      shift_d = '0;
      cnt_d   = '0;
    end else if (rise) begin
      shift_d = {shift_q[6:0], din_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        data_d  = shift_d;
        dc_d    = dc_s;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      dc_q    <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = data_q;
  assign byte_dc    = dc_q;

endmodule

// File: rtl/oled_spi_rx.sv
// OLED 4-wire SPI receiver / display emulator front end.
// Receives bytes via oled_spi_shifter, decodes window/display commands and turns data bytes
// into auto-incrementing frame-buffer writes (one byte = two 4-bit pixels).
// Ports:
//   clk, rst                       system clock, async active-high reset
//   oled_clk, din, cs, dc, res_n   serial target inputs
//   byte_valid, byte_data, byte_dc received byte stream
//   pix_we, pix_addr, pix_data     frame-buffer write port (row*COL_BYTES+col)
//   display_on                     display enable state
//   cmd_err                        pulse when a data byte interrupts a pending command
module oled_spi_rx
  import oled_pkg::*;
#(
  parameter int unsigned COL_BYTES   = 64,
  parameter int unsigned ROWS        = 64,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              oled_clk,
  input  logic              din,
  input  logic              cs,
  input  logic              dc,
  input  logic              res_n,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              byte_dc,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              display_on,
  output logic              cmd_err
);

  localparam int unsigned COL_W = (COL_BYTES > 1) ? $clog2(COL_BYTES) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [7:0] COL_MAX = 8'(COL_BYTES - 1);
  localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);

  logic res_act, is_cmd, is_data;

  oled_spi_shifter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .oled_clk  (oled_clk),
    .din       (din),
    .cs        (cs),
    .dc        (dc),
    .res_n     (res_n),
    .res_act   (res_act),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_dc   (byte_dc)
  );

  dec_state_e       state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [1:0]       remain_q, remain_d;
  logic [7:0]       arg0_q, arg0_d;
  logic [COL_W-1:0] col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
  logic [ROW_W-1:0] row_start_q, row_start_d, row_end_q, row_end_d, row_q, row_d;
  logic             disp_q, disp_d;

  logic [7:0] s_col8, e_col8, s_row8, e_row8;

  assign is_cmd  = byte_valid & ~byte_dc & ~res_act;
  assign is_data = byte_valid & byte_dc & ~res_act;

  assign pix_we     = is_data;
  assign cmd_err    = is_data & (state_q == ARG);
  assign pix_data   = byte_data;
  assign pix_addr   = ADDR_W'(row_q) * ADDR_W'(COL_BYTES) + ADDR_W'(col_q);
  assign display_on = disp_q;

  // Window bounds: first argument held in arg0_q, second is the byte now arriving.
  always_comb begin
    s_col8 = clamp8(arg0_q, COL_MAX);
    e_col8 = clamp8(byte_data, COL_MAX);
    if (s_col8 > e_col8) e_col8 = s_col8;
    s_row8 = clamp8(arg0_q, ROW_MAX);
    e_row8 = clamp8(byte_data, ROW_MAX);
    if (s_row8 > e_row8) e_row8 = s_row8;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    remain_d    = remain_q;
    arg0_d      = arg0_q;
    col_start_d = col_start_q;
    col_end_d   = col_end_q;
    col_d       = col_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    row_d       = row_q;
    disp_d      = disp_q;

    if (is_cmd) begin
      if (state_q == IDLE) begin
        if (byte_data == CMD_DISP_OFF) begin
          disp_d = 1'b0;
        end else if (byte_data == CMD_DISP_ON) begin
          disp_d = 1'b1;
        end else if (arg_count(byte_data) != 2'd0) begin
          state_d  = ARG;
          op_d     = byte_data;
          remain_d = arg_count(byte_data);
        end
      end else begin
        remain_d = remain_q - 2'd1;
        if (remain_q == 2'd2) arg0_d = byte_data;
        if (remain_q == 2'd1) begin
          state_d = IDLE;
          if (op_q == CMD_COL_ADDR) begin
            col_start_d = COL_W'(s_col8);
            col_end_d   = COL_W'(e_col8);
            col_d       = COL_W'(s_col8);
          end else if (op_q == CMD_ROW_ADDR) begin
            row_start_d = ROW_W'(s_row8);
            row_end_d   = ROW_W'(e_row8);
            row_d       = ROW_W'(s_row8);
          end
        end
      end
    end else if (is_data) begin
      // A data byte abandons any pending command; the write itself still happens.
      state_d  = IDLE;
      remain_d = 2'd0;
      if (col_q == col_end_q) begin
        col_d = col_start_q;
        row_d = (row_q == row_end_q) ? row_start_q : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (res_act) begin
      state_d     = IDLE;
      op_d        = '0;
      remain_d    = '0;
      arg0_d      = '0;
      col_start_d = '0;
      col_end_d   = COL_W'(COL_BYTES - 1);
      col_d       = '0;
      row_start_d = '0;
      row_end_d   = ROW_W'(ROWS - 1);
      row_d       = '0;
      disp_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      remain_q    <= '0;
      arg0_q      <= '0;
      col_start_q <= '0;
      col_end_q   <= COL_W'(COL_BYTES - 1);
      col_q       <= '0;
      row_start_q <= '0;
      row_end_q   <= ROW_W'(ROWS - 1);
      row_q       <= '0;
      disp_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      remain_q    <= remain_d;
      arg0_q      <= arg0_d;
      col_start_q <= col_start_d;
      col_end_q   <= col_end_d;
      col_q       <= col_d;
      row_start_q <= row_start_d;
      row_end_q   <= row_end_d;
      row_q       <= row_d;
      disp_q      <= disp_d;
    end
  end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scoreboard bench for oled_spi_rx: stimulus pushes expected byte records, a negedge monitor
// pops and compares whenever byte_valid is seen.
module tb_oled_spi_rx;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst, oled_clk, din, cs, dc, res_n;
  logic        byte_valid, byte_dc, pix_we, display_on, cmd_err;
  logic [7:0]  byte_data, pix_data;
  logic [11:0] pix_addr;

  oled_spi_rx #(
    .COL_BYTES  (64),
    .ROWS       (64),
    .ADDR_W     (12),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .oled_clk  (oled_clk),
    .din       (din),
    .cs        (cs),
    .dc        (dc),
    .res_n     (res_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_dc   (byte_dc),
    .pix_we    (pix_we),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .display_on(display_on),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        dc;
    logic        we;
    logic [11:0] addr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int edge_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && byte_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_byte: got 0x%0h, required none", byte_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("byte_data", 32'(byte_data), 32'(mon_e.data));
        chk("byte_dc", 32'(byte_dc), 32'(mon_e.dc));
        chk("pix_we", 32'(pix_we), 32'(mon_e.we));
        if (mon_e.we) begin
          chk("pix_addr", 32'(pix_addr), 32'(mon_e.addr));
          chk("pix_data", 32'(pix_data), 32'(mon_e.data));
        end
        chk("cmd_err", 32'(cmd_err), 32'(mon_e.err));
        chk("latency_ok", 32'((cyc - edge_cyc) <= SYNC_STAGES + 2), 32'd1);
      end
    end else if (pix_we || cmd_err) begin
      tests++;
      fails++;
      $display("FAIL stray_strobe: got we=%0d err=%0d, required 0", pix_we, cmd_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs change on the falling clk edge; oled_clk period is 8 clk.
  task automatic send_bits(input logic [7:0] b, input int n, input logic dcv);
    for (int i = 7; i > 7 - n; i--) begin
      din = b[i];
      dc  = dcv;
      tick(4);
      oled_clk = 1'b1;
      if (i == 0) edge_cyc = cyc;
      tick(4);
      oled_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dcv);
    send_bits(b, 8, dcv);
  endtask

  task automatic cmd(input logic [7:0] b);
    exp_q.push_back('{data: b, dc: 1'b0, we: 1'b0, addr: 12'd0, err: 1'b0});
    send_byte(b, 1'b0);
  endtask

  task automatic dat(input logic [7:0] b, input logic [11:0] a, input logic err);
    exp_q.push_back('{data: b, dc: 1'b1, we: 1'b1, addr: a, err: err});
    send_byte(b, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    chk(name, 32'(exp_q.size()), 32'd0);
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; oled_clk = 1'b0; din = 1'b0; cs = 1'b1; dc = 1'b0; res_n = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    chk("reset_display_on", 32'(display_on), 32'd0);
    chk("reset_pix_addr", 32'(pix_addr), 32'd0);
    chk("reset_byte_data", 32'(byte_data), 32'd0);

    // Display on command
    cs = 1'b0;
    cmd(8'hAF);
    drain("drain_af");
    chk("display_on_after_af", 32'(display_on), 32'd1);

    // Async reset in the middle of a byte
    send_bits(8'hFF, 4, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_display_on", 32'(display_on), 32'd0);
    chk("rst_outputs", 32'({byte_valid, byte_dc, pix_we, cmd_err, byte_data, pix_data}), 32'd0);
    chk("rst_pix_addr", 32'(pix_addr), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(4);
    dat(8'h3C, 12'd0, 1'b0);
    drain("drain_rst");

    // Window wrap: cols 2..3, rows 5..6
    cmd(8'h15); cmd(8'h02); cmd(8'h03);
    cmd(8'h75); cmd(8'h05); cmd(8'h06);
    dat(8'h11, 12'd322, 1'b0);
    dat(8'h22, 12'd323, 1'b0);
    dat(8'h33, 12'd386, 1'b0);
    dat(8'h44, 12'd387, 1'b0);
    dat(8'h55, 12'd322, 1'b0);
    drain("drain_window");

    // CS abort after 5 bits
    send_bits(8'hFF, 5, 1'b0);
    cs = 1'b1;
    tick(16);
    cs = 1'b0;
    cmd(8'hA5);
    drain("drain_cs_abort");

    // Protocol error: data interrupts a pending one-argument command
    cmd(8'hAF);
    drain("drain_af2");
    chk("display_on_before_err", 32'(display_on), 32'd1);
    cmd(8'h81);
    dat(8'h77, 12'd323, 1'b1);
    cmd(8'hAE);
    drain("drain_err");
    chk("display_off_after_ae", 32'(display_on), 32'd0);

    // Clamp: start 0x50 -> 63, end 0x10 -> 16 -> raised to 63; pointer now (6,63)
    cmd(8'hAF);
    cmd(8'h15); cmd(8'h50); cmd(8'h10);
    dat(8'h99, 12'd447, 1'b0);
    drain("drain_clamp");

    // Display reset
    res_n = 1'b0;
    tick(6);
    res_n = 1'b1;
    tick(6);
    chk("res_display_on", 32'(display_on), 32'd0);
    chk("res_pix_addr", 32'(pix_addr), 32'd0);
    dat(8'h5A, 12'd0, 1'b0);
    dat(8'h6B, 12'd1, 1'b0);
    drain("drain_res");

    cs = 1'b1;
    tick(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- Receive-side counterpart of the OLED serial command/data writer: a 4-wire SPI target (DIN, OLED_CLK, CS, DC, RES) running in the system clock domain.
- Oversamples the serial lines, assembles MSB-first bytes and classifies them as command or data.
- Decodes the column/row window commands and turns data bytes into auto-incrementing frame-buffer writes, one byte holding 2 pixels at 4 bpp.
- Used as an on-chip display emulator and as the scoreboard front end in display benches.

Parameters:
- COL_BYTES, 64, byte columns per row (128 px / 2).
- ROWS, 64, display rows.
- ADDR_W, 12, frame-buffer address width; must satisfy 2^ADDR_W >= COL_BYTES*ROWS.
- SYNC_STAGES, 2, synchronizer flops on every serial input.

Ports:
- clk, in, 1, system clock; must be at least 4x the OLED_CLK frequency.
- rst, in, 1, asynchronous active-high reset.
- oled_clk, in, 1, serial clock; DIN is sampled on its rising edge.
- din, in, 1, serial data, MSB first.
- cs, in, 1, chip select, active low.
- dc, in, 1, 0 = command, 1 = data; sampled together with bit 0.
- res_n, in, 1, display reset, active low.
- byte_valid, out, 1, one-cycle pulse per received byte.
- byte_data, out, 8, received byte.
- byte_dc, out, 1, DC value captured for that byte.
- pix_we, out, 1, frame-buffer write strobe.
- pix_addr, out, ADDR_W, row*COL_BYTES + col.
- pix_data, out, 8, two 4-bit pixels; the high nibble is the left pixel.
- display_on, out, 1, 1 after 0xAF, 0 after 0xAE.
- cmd_err, out, 1, one-cycle pulse on a protocol violation.

Behaviour:
- Reset (rst=1, async): all outputs 0. Shift register, bit counter and decoder go to IDLE. Windows: col 0..COL_BYTES-1, row 0..ROWS-1. Pointer at (0,0).
- Input conditioning: oled_clk, din, cs and dc each pass through SYNC_STAGES flops. A rising edge is synced clk high while the previous synced sample was low.
- Bit capture: on each rising edge with synced cs=0, shift in din and increment a 3-bit counter.
- On the 8th bit:
  - Register byte_data and byte_dc (dc taken at that edge).
  - Pulse byte_valid the next cycle.
  - byte_valid is asserted no later than SYNC_STAGES+2 clk cycles after the physical 8th edge.
- cs high at any time: discard partial bits, clear the counter, emit no byte. Decoder state is kept across CS frames.
- res_n low (synchronized): same effect as rst on the decoder, windows, pointer and display_on. The byte shifter is also cleared.
- Decoder FSM, states IDLE and ARG:
  - IDLE + command byte:
    - 0xAE: display_on=0.
    - 0xAF: display_on=1.
    - Otherwise look up the argument count n from the package table. n>0 -> ARG with the opcode latched and remain=n.
  - ARG + command byte: store the argument and decrement remain. remain hits 0 -> apply the command and return to IDLE.
  - 0x15 args (s,e): col window. 0x75 args (s,e): row window.
    - Arguments are clamped to COL_BYTES-1 or ROWS-1 respectively.
    - If s>e then e:=s.
    - Applying a window sets the pointer axis to s.
  - All other opcodes are consumed and ignored.
  - Any data byte: pix_we=1 for one cycle, in the same cycle as byte_valid, with pix_addr at the current pointer and pix_data=byte.
  - Data byte while in ARG: pulse cmd_err, abandon the pending command, return to IDLE, and still perform the pixel write.
- Pointer advance after each pixel write:
  - col==col_end -> col=col_start and row++.
  - row==row_end on that wrap -> row=row_start.
  - Otherwise col++.
- Pointer arithmetic is unsigned. pix_addr is computed as row*COL_BYTES+col truncated to ADDR_W.
- A new window or pointer takes effect from the next byte.

Decomposition:
- Package oled_pkg holds:
  - opcode constants: CMD_COL_ADDR=0x15, CMD_ROW_ADDR=0x75, CMD_DISP_OFF=0xAE, CMD_DISP_ON=0xAF.
  - function arg_count(opcode): 2 for 0x15/0x75; 0 for 0xA4–0xA7/0xAE/0xAF/0xE3; 1 for all others.
  - decoder state enum {IDLE, ARG}.
- One sub-module, oled_spi_shifter: synchronizers, edge detect, bit counter, byte_valid/byte_data/byte_dc. The decoder and pointer live in the top.

Test Plan:
- Reset: assert rst mid-byte (4 bits shifted) -> all outputs 0 immediately. After release, a full byte 0x3C is received cleanly with no stale bits.
- Command: OLED_CLK period 8 clk, CS low, DC=0, shift 0xAF -> single byte_valid with byte_data=0xAF, byte_dc=0. display_on rises to 1; pix_we stays 0.
- Window wrap: commands 0x15,0x02,0x03 then 0x75,0x05,0x06, then data 0x11,0x22,0x33,0x44,0x55.
  - Required pix_addr sequence: 322, 323, 386, 387, 322.
  - Required pix_data: 0x11..0x55.
- CS abort: 5 bits shifted, CS high for 16 clk, then CS low and full byte 0xA5 -> exactly one byte_valid with 0xA5.
- Protocol error: command 0x81, then data byte 0x77 -> cmd_err pulses once and pix_we writes 0x77 at the current pointer. A following 0xAE is decoded correctly (display_on=0).
- Clamp and res_n:
  - Command 0x15,0x50,0x10 -> col window 63..63.
  - Then pulse res_n low -> windows back to 0..63/0..63, pointer (0,0). The next data byte writes pix_addr=0.
